// File: rtl/fp_pkg.sv
// Shared constants for the SQIsign base-field datapath: modulus, Fermat exponent,
// fp_mul latency and the fp_inv state encoding.
package fp_pkg;

    localparam int FP_WIDTH       = 255;
    localparam int FP_MUL_LATENCY = 4;

    // P = 5*2^248 - 1, so P-2 needs 251 bits with its MSB set
    localparam int                   EXP_BITS  = 251;
    localparam logic [FP_WIDTH-1:0]  P         = (FP_WIDTH'(5) << 248) - FP_WIDTH'(1);
    localparam logic [EXP_BITS-1:0]  P_MINUS_2 = EXP_BITS'(P - FP_WIDTH'(2));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQ_ISSUE,
        ST_MU_ISSUE,
        ST_WAIT,
        ST_DONE
    } inv_state_t;

    // Multiplications per inversion: one square per bit below the MSB,
    // one multiply per set bit below the MSB.
    function automatic int n_ops(input logic [EXP_BITS-1:0] e);
        int pop;
        pop = 0;
        for (int i = 0; i < EXP_BITS; i++) begin
            pop += int'(e[i]);
        end
        return (EXP_BITS - 1) + (pop - 1);
    endfunction

endpackage

// File: rtl/fp_mul.sv
// Modular multiplier D = A*B mod P, fixed four-cycle pipeline:
// operand register, full product, reduction, output register.
module fp_mul
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [FP_WIDTH-1:0] A,
    input  logic [FP_WIDTH-1:0] B,
    output logic [FP_WIDTH-1:0] D
);

    localparam int LATENCY_MUL = 4;
    localparam logic [2*FP_WIDTH-1:0] P_WIDE = {{FP_WIDTH{1'b0}}, P};

    if (LATENCY_MUL != FP_MUL_LATENCY) begin : g_lat_check
        $error("fp_mul: pipeline depth does not match FP_MUL_LATENCY");
    end

    logic [FP_WIDTH-1:0]   a_q;
    logic [FP_WIDTH-1:0]   b_q;
    logic [2*FP_WIDTH-1:0] prod_q;
    logic [FP_WIDTH-1:0]   red_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            red_q  <= '0;
            D      <= '0;
        end else begin
            a_q    <= A;
            b_q    <= B;
            prod_q <= {{FP_WIDTH{1'b0}}, a_q} * {{FP_WIDTH{1'b0}}, b_q};
            red_q  <= FP_WIDTH'(prod_q % P_WIDE);
            D      <= red_q;
        end
    end

endmodule

// File: rtl/fp_inv.sv
// Fermat field inverter inv = a^(P-2) mod P, square-and-multiply over one fp_mul.
// Optional FP_INV_ZERO_FLAG_EN: zero operand short-cuts to done and raises zero_err.
//
//  state     | meaning
//  ----------+-------------------------------------------------------
//  IDLE      | waiting for start; operand latched on acceptance
//  SQ_ISSUE  | fp_mul operands hold r, r
//  MU_ISSUE  | fp_mul operands hold r, a_reg
//  WAIT      | counting fp_mul latency; last cycle captures D into r
//  DONE      | publish r on inv_out, pulse done, drop busy
module fp_inv
    import fp_pkg::*;
#(
    parameter int WIDTH   = FP_WIDTH,
    parameter int LAT_MUL = FP_MUL_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] inv_out
`ifdef FP_INV_ZERO_FLAG_EN
    ,
    output logic             zero_err
`endif
);

    localparam int BIT_W = $clog2(EXP_BITS);
    localparam int LAT_W = $clog2(LAT_MUL + 1);
    localparam logic [BIT_W-1:0] BIT_START = BIT_W'(EXP_BITS - 2);
    localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(LAT_MUL - 1);

    if (WIDTH != FP_WIDTH || LAT_MUL != FP_MUL_LATENCY) begin : g_param_check
        $error("fp_inv: WIDTH/LAT_MUL must match fp_mul");
    end

    inv_state_t       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_d;
    logic [BIT_W-1:0] bit_idx;
    logic [LAT_W-1:0] lat_cnt;
    logic             kind_mu;
`ifdef FP_INV_ZERO_FLAG_EN
    logic             zero_pend;
`endif

    fp_mul u_mul (
        .clk (clk),
        .rst (rst),
        .A   (mul_a),
        .B   (mul_b),
        .D   (mul_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            inv_out   <= '0;
            a_reg     <= '0;
            r         <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            bit_idx   <= '0;
            lat_cnt   <= '0;
            kind_mu   <= 1'b0;
`ifdef FP_INV_ZERO_FLAG_EN
            zero_pend <= 1'b0;
            zero_err  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg   <= a_in;
                        r       <= a_in;
                        mul_a   <= a_in;
                        mul_b   <= a_in;
                        bit_idx <= BIT_START;
                        busy    <= 1'b1;
                        state   <= ST_SQ_ISSUE;
`ifdef FP_INV_ZERO_FLAG_EN
                        zero_pend <= (a_in == '0);
                        zero_err  <= 1'b0;
`endif
                    end
                end
                ST_SQ_ISSUE: begin
                    kind_mu <= 1'b0;
                    lat_cnt <= LAT_LOAD;
                    state   <= ST_WAIT;
`ifdef FP_INV_ZERO_FLAG_EN
                    // zero operand: the issued square is abandoned, result is r = 0
                    if (zero_pend) state <= ST_DONE;
`endif
                end
                ST_MU_ISSUE: begin
                    kind_mu <= 1'b1;
                    lat_cnt <= LAT_LOAD;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end else begin
                        r     <= mul_d;
                        mul_a <= mul_d;
                        if (!kind_mu && P_MINUS_2[bit_idx]) begin
                            mul_b <= a_reg;
                            state <= ST_MU_ISSUE;
                        end else if (bit_idx == '0) begin
                            state <= ST_DONE;
                        end else begin
                            bit_idx <= bit_idx - BIT_W'(1);
                            mul_b   <= mul_d;
                            state   <= ST_SQ_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    inv_out <= r;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
`ifdef FP_INV_ZERO_FLAG_EN
                    zero_err <= zero_pend;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
